stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control FSM for the 4-digit BCD stopwatch chain (ms/cs/ds/s). It converts the two raw push-buttons into debounced press events and sequences run/pause/lap/reset. It gates the 1 kHz tick into the chain's enable, generates the chain's active-low synchronous clear, and freezes the display for lap readout. It sits between the clock divider/KEY inputs and the BCD counter chain plus the SevenSeg display registers.

Parameters:
DEB_CYCLES, 500000, clk cycles a synchronized key must differ from its debounced level before it is accepted (10 ms at 50 MHz); legal range 1..2^20-1.
CLR_CYCLES, 2, cycles cnt_clear_ is held low per clear sequence; legal range 1..15.

Ports:
clk  input  1  system clock (MAX10_CLK1_50 domain).
clear_  input  1  asynchronous, active-low reset.
key_ss_n  input  1  raw start/stop button, active-low (pressed = 0), asynchronous.
key_lr_n  input  1  raw lap/reset button, active-low, asynchronous.
tick_1khz  input  1  one-clk-wide strobe from the clock divider, 1 per ms.
chain_max  input  1  high while the chain reads 9.999 (all digits 9).
cnt_tick  output  1  registered enable pulse to the ms counter, one clk wide.
cnt_clear_  output  1  active-low synchronous clear to all four BCD counters.
disp_freeze  output  1  high = display latches hold the last value.
run_led  output  1  high while counting (RUNNING or LAP).
state  output  3  current FSM state encoding, for LEDR/debug.

Behaviour:
- Reset (clear_=0, async): state=CLEARING, clear counter loaded with CLR_CYCLES-1, cnt_tick=0, cnt_clear_=0, disp_freeze=0, run_led=0, debounced levels=1, synchronizers=1.
- State encoding: IDLE=0, RUNNING=1, LAP=2, PAUSED=3, OVERFLOW=4, CLEARING=5; 6/7 are illegal and go to CLEARING on the next edge.
- Input synchronization: each key passes through 2 flops (s1, s2).
- Debounce (per key): cnt increments while s2 != deb and resets to 0 while s2 == deb. When cnt == DEB_CYCLES-1 and the mismatch persists, deb <= s2 and cnt <= 0.
- Press event: ev = deb_prev & ~deb, where deb_prev is deb registered. Release makes no event. A glitch shorter than DEB_CYCLES cycles makes no event.
- Latency: a raw key held low from edge 0 sets deb=0 at edge DEB_CYCLES+2. The FSM transitions at edge DEB_CYCLES+3.
- Both events in the same cycle: ss wins and lr is discarded, except in OVERFLOW, where only lr is honoured.
- Transitions (any state not listed holds):
  - IDLE: ss -> RUNNING.
  - RUNNING: ss -> PAUSED; lr -> LAP.
  - LAP: lr -> RUNNING; ss -> PAUSED.
  - PAUSED: ss -> RUNNING; lr -> CLEARING.
  - OVERFLOW: lr -> CLEARING.
  - CLEARING: counts down CLR_CYCLES cycles, then -> IDLE; all events are ignored.
- Overflow: in RUNNING/LAP, when tick_1khz=1 and chain_max=1, the next state is OVERFLOW and that tick is not forwarded. The chain holds 9.999.
- cnt_tick (registered): next value = tick_1khz & (state is RUNNING or LAP) & ~(chain_max), evaluated on the current state.
  - It appears 1 clk after tick_1khz and is always one clk wide.
  - A tick coinciding with an ss-to-PAUSED event is still forwarded.
- cnt_clear_ = 0 exactly while state==CLEARING (registered, CLR_CYCLES cycles), otherwise 1.
- disp_freeze = 1 iff state==LAP (registered with state). PAUSED and OVERFLOW show the live, static value.
- run_led = 1 iff state is RUNNING or LAP.
- Reset mid-operation: all outputs take their reset values immediately. After release, the block performs a CLR_CYCLES clear and then goes to IDLE.
- A key held down produces one event only. Its release must also be debounced before the next press is accepted.

Test Plan:
- DEB_CYCLES=4, CLR_CYCLES=2. Release reset -> cnt_clear_=0 for 2 cycles, then state=0, cnt_tick=0.
- From IDLE, hold key_ss_n=0 for 20 cycles, then drive tick pulses every 10 cycles:
  - state=1 at edge 7 after the key falls;
  - each cnt_tick is exactly 1 clk, delayed 1 clk from its tick;
  - one event only.
- Pulse key_ss_n low for 3 cycles (shorter than DEB_CYCLES) -> no state change, no event.
- In RUNNING, press lr:
  - state=2, disp_freeze=1, cnt_tick continues;
  - press lr again -> state=1, disp_freeze=0;
  - press ss -> state=3, cnt_tick stops;
  - press lr -> cnt_clear_ low 2 cycles, state=0.
- In RUNNING, hold chain_max=1 and pulse tick -> no cnt_tick, state=4. A ss press does nothing; a lr press -> CLEARING -> IDLE.
- Assert clear_=0 mid-LAP with a tick pending -> disp_freeze/cnt_tick go 0 at once and cnt_clear_=0. Both keys pressed in the same cycle from RUNNING -> state=3 (ss wins).

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for the 4-digit BCD stopwatch chain (ms/cs/ds/s).
//   - Synchronizes and debounces the two raw push-buttons and turns each
//     debounced press (high-to-low) into a one-cycle event.
//   - Sequences IDLE / RUNNING / LAP / PAUSED / OVERFLOW / CLEARING.
//   - Forwards the 1 kHz tick to the counter chain while counting, issues the
//     chain's synchronous clear and freezes the display during lap readout.
//
// Ports
//   clk          system clock
//   clear_       asynchronous active-low reset
//   key_ss_n     raw start/stop button, active-low, asynchronous
//   key_lr_n     raw lap/reset button, active-low, asynchronous
//   tick_1khz    one-clk strobe per millisecond from the clock divider
//   chain_max    high while the chain reads 9.999
//   cnt_tick     registered one-clk enable pulse to the ms counter
//   cnt_clear_   registered active-low synchronous clear for the chain
//   disp_freeze  high while the display latches hold (lap readout)
//   run_led      high while counting (RUNNING or LAP)
//   state        current FSM state encoding for LEDs/debug
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,  // 1 .. 2^20-1
    parameter int CLR_CYCLES = 2        // 1 .. 15
) (
    input  logic       clk,
    input  logic       clear_,
    input  logic       key_ss_n,
    input  logic       key_lr_n,
    input  logic       tick_1khz,
    input  logic       chain_max,
    output logic       cnt_tick,
    output logic       cnt_clear_,
    output logic       disp_freeze,
    output logic       run_led,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_LAP      = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_OVERFLOW = 3'd4,
        ST_CLEARING = 3'd5
    } state_t;

    localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);
    localparam logic [3:0]  CLR_LOAD = 4'(CLR_CYCLES - 1);

    // Index 0 = start/stop key, index 1 = lap/reset key.
    logic [1:0]  keys;
    logic [1:0]  s1, s2;
    logic [1:0]  deb, deb_prev;
    logic [19:0] deb_cnt [2];
    logic [1:0]  ev;
    logic        ss_ev, lr_ev;

    state_t      cur, nxt;
    logic [3:0]  clr_cnt;
    logic        counting;
    logic        tick_nxt;

    assign keys = {key_lr_n, key_ss_n};

    // ---------------------------------------------------------------- debounce
    // deb only follows s2 after it has disagreed for DEB_CYCLES consecutive
    // cycles; any agreement in between restarts the count, so glitches and
    // bounce shorter than that are swallowed in both directions.
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            s1       <= '1;
            s2       <= '1;
            deb      <= '1;
            deb_prev <= '1;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so s1->s2 really is a two-stage synchronizer.
            s1       <= keys;
            s2       <= s1;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 20'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press = debounced level falling; release produces nothing.
    assign ev    = deb_prev & ~deb;
    assign ss_ev = ev[0];
    assign lr_ev = ev[1];

    // --------------------------------------------------------- next state
    assign counting = (cur == ST_RUNNING) || (cur == ST_LAP);
    assign tick_nxt = tick_1khz & counting & ~chain_max;

    always_comb begin
        // NOTE: nxt gets its hold value first so every path assigns it and no
        // latch is inferred.
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (ss_ev) nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                // Hitting 9.999 on a tick overrides any key activity.
                if (tick_1khz && chain_max) nxt = ST_OVERFLOW;
                else if (ss_ev)             nxt = ST_PAUSED;
                else if (lr_ev)             nxt = ST_LAP;
            end
            ST_LAP: begin
                if (tick_1khz && chain_max) nxt = ST_OVERFLOW;
                else if (ss_ev)             nxt = ST_PAUSED;
                else if (lr_ev)             nxt = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (ss_ev)      nxt = ST_RUNNING;
                else if (lr_ev) nxt = ST_CLEARING;
            end
            ST_OVERFLOW: begin
                // Start/stop is meaningless at 9.999; only lap/reset counts.
                if (lr_ev) nxt = ST_CLEARING;
            end
            ST_CLEARING: begin
                if (clr_cnt == '0) nxt = ST_IDLE;
            end
            default: nxt = ST_CLEARING;  // 6/7 recover through a clear
        endcase
    end

    // ------------------------------------------------- state and outputs
    // Outputs are decoded from nxt into flops so they change together with
    // state and never glitch toward the counter chain or display.
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            cur         <= ST_CLEARING;
            clr_cnt     <= CLR_LOAD;
            cnt_tick    <= 1'b0;
            cnt_clear_  <= 1'b0;
            disp_freeze <= 1'b0;
            run_led     <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == ST_CLEARING && cur != ST_CLEARING) begin
                clr_cnt <= CLR_LOAD;
            end else if (cur == ST_CLEARING && clr_cnt != '0) begin
                clr_cnt <= clr_cnt - 4'd1;
            end
            cnt_tick    <= tick_nxt;
            cnt_clear_  <= (nxt != ST_CLEARING);
            disp_freeze <= (nxt == ST_LAP);
            run_led     <= (nxt == ST_RUNNING) || (nxt == ST_LAP);
        end
    end

    assign state = cur;

endmodule
